adc_spi_muestreador: RTL and testbench

Front-end sampler that produces the filter input stream. It paces sample periods, reads a 12-bit serial ADC (AD7476-style: CS_n, SCLK, SDATA, 16-clock frame with 4 leading zeros), converts the offset-binary code to N-bit signed fixed point, and presents it on Uk with a one-cycle Bandera_ADC strobe. Sits directly upstream of the low-pass filter blocks (Uk/Bandera_ADC feed their Uk/Bandera_ADC inputs).

---
 rtl/adc_spi_muestreador_if.sv | 24 ++
 rtl/adc_spi_muestreador.sv | 129 ++++++++++++
 tb/tb_adc_spi_muestreador.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_muestreador_if.sv
// Bus between the ADC sampler and its neighbours: ADC serial pins, run enable,
// and the Uk / Bandera_ADC sample stream with the sticky status flags.
interface adc_spi_muestreador_if #(
    parameter int N = 25
);
    logic                Enable;
    logic                SDATA;
    logic                SCLK;
    logic                CS_n;
    logic signed [N-1:0] Uk;
    logic                Bandera_ADC;
    logic                Overrun;
    logic                Error_Trama;

    modport master (
        input  Enable, SDATA,
        output SCLK, CS_n, Uk, Bandera_ADC, Overrun, Error_Trama
    );

    modport slave (
        output Enable, SDATA,
        input  SCLK, CS_n, Uk, Bandera_ADC, Overrun, Error_Trama
    );
endinterface

// File: rtl/adc_spi_muestreador.sv
// Sample-period pacer and AD7476-style serial ADC reader producing signed Q(N-FRAC).FRAC samples.
// Optional macro ADC_FRAME_CHECK_EN: discard frames whose 4 leading bits are not all zero.
module adc_spi_muestreador #(
    parameter int N          = 25,
    parameter int FRAC       = 15,
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_DIV = 2500
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    adc_spi_muestreador_if.master   bus
);
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DW = $clog2(CLK_DIV);
`ifdef ADC_FRAME_CHECK_EN
    localparam int SW = 16;
`else
    localparam int SW = 12;
`endif

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t              state_q;
    logic [TW-1:0]       tmr_q;
    logic [DW-1:0]       div_q;
    logic [5:0]          edge_q;
    logic [SW-1:0]       shift_q;
    logic                sclk_q;
    logic                csn_q;
    logic signed [N-1:0] uk_q;
    logic                flag_q;
    logic                ovr_q;
`ifdef ADC_FRAME_CHECK_EN
    logic                err_q;
`endif

    logic                tick;
    logic                frame_ok;
    logic signed [N-1:0] uk_d;

    // Offset-binary to two's complement is an MSB flip; the left shift is exact.
    function automatic logic signed [N-1:0] to_fixed(input logic [11:0] code);
        logic signed [11:0]  s;
        logic signed [N-1:0] ext;
        s   = signed'({~code[11], code[10:0]});
        ext = {{(N-12){s[11]}}, s};
        return ext <<< (FRAC - 11);
    endfunction

    assign tick = bus.Enable && (tmr_q == TW'(SAMPLE_DIV - 1));
    assign uk_d = to_fixed(shift_q[11:0]);

`ifdef ADC_FRAME_CHECK_EN
    assign frame_ok        = (shift_q[15:12] == 4'b0000);
    assign bus.Error_Trama = err_q;
`else
    assign frame_ok        = 1'b1;
    assign bus.Error_Trama = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            div_q   <= '0;
            edge_q  <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b1;
            csn_q   <= 1'b1;
            uk_q    <= '0;
            flag_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef ADC_FRAME_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            flag_q <= 1'b0;

            if (!bus.Enable || tick) tmr_q <= '0;
            else                     tmr_q <= tmr_q + TW'(1);

            if (tick && state_q != IDLE) ovr_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    csn_q  <= 1'b1;
                    sclk_q <= 1'b1;
                    if (tick) begin
                        state_q <= CONV;
                        csn_q   <= 1'b0;
                        div_q   <= '0;
                        edge_q  <= '0;
                    end
                end
                CONV: begin
                    // One settling cycle after the 16th rising edge, then load.
                    if (edge_q == 6'd32) begin
                        state_q <= LOAD;
                        csn_q   <= 1'b1;
                        if (frame_ok) begin
                            uk_q   <= uk_d;
                            flag_q <= 1'b1;
                        end
`ifdef ADC_FRAME_CHECK_EN
                        else begin
                            err_q <= 1'b1;
                        end
`endif
                    end else if (div_q == DW'(CLK_DIV - 1)) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 6'd1;
                        if (!sclk_q) shift_q <= {shift_q[SW-2:0], bus.SDATA};
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                LOAD:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.SCLK        = sclk_q;
    assign bus.CS_n        = csn_q;
    assign bus.Uk          = uk_q;
    assign bus.Bandera_ADC = flag_q;
    assign bus.Overrun     = ovr_q;
endmodule

// File: tb/tb_adc_spi_muestreador.sv
// Bench for adc_spi_muestreador: ADC serial models, frame-level reference model,
// vector table on a default-rate instance and random frames on an overrunning instance.
module tb_adc_spi_muestreador;
    localparam int N       = 25;
    localparam int FRAC    = 15;
    localparam int CLK_DIV = 4;
    localparam int LAT     = 32 * CLK_DIV + 1;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_muestreador_if #(.N(N)) ifa ();
    adc_spi_muestreador_if #(.N(N)) ifb ();

    adc_spi_muestreador #(.N(N), .FRAC(FRAC), .CLK_DIV(CLK_DIV), .SAMPLE_DIV(2500)) dut_a (
        .Clk(clk), .Reset_n(rst_a_n), .bus(ifa.master));
    adc_spi_muestreador #(.N(N), .FRAC(FRAC), .CLK_DIV(CLK_DIV), .SAMPLE_DIV(100)) dut_b (
        .Clk(clk), .Reset_n(rst_b_n), .bus(ifb.master));

    // ADC models: a frame word is chosen at CS_n fall, the next bit is presented after each SCLK rise.
    logic [15:0] adc_q[$];
    logic [15:0] frame[2];
    int          nrise[2];

    always @(negedge ifa.CS_n) begin
        nrise[0] = 0;
        if (adc_q.size() > 0) frame[0] = adc_q.pop_front();
        else                  frame[0] = {4'b0000, 12'($urandom)};
    end
    always @(posedge ifa.SCLK) if (!ifa.CS_n) nrise[0]++;
    assign ifa.SDATA = (nrise[0] < 16) ? frame[0][15 - nrise[0]] : 1'b0;

    always @(negedge ifb.CS_n) begin
        nrise[1] = 0;
        frame[1] = {(($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000), 12'($urandom)};
    end
    always @(posedge ifb.SCLK) if (!ifb.CS_n) nrise[1]++;
    assign ifb.SDATA = (nrise[1] < 16) ? frame[1][15 - nrise[1]] : 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: Uk value = (code - 2048) * 2^(FRAC-11).
    function automatic longint exp_uk(input logic [15:0] fr);
        return (longint'(fr[11:0]) - 64'sd2048) * (64'sd1 <<< (FRAC - 11));
    endfunction

    int          cs_prev[2], sclk_prev[2], in_frame[2], falls[2], fall_cyc[2];
    int          last_load[2], load_cnt[2], ld_strobe[2];
    logic [N-1:0] uk_prev[2], ld_uk[2];

    task automatic monitor(input int id, input logic rst_n, input logic cs, input logic sclk,
                           input logic stb, input logic [N-1:0] uk, input logic err, input int spacing);
        bit exp_stb;
        if (!rst_n) begin
            in_frame[id]  = 0;
            last_load[id] = -1;
        end else begin
            if (cs_prev[id] == 1 && !cs) begin
                in_frame[id] = 1;
                fall_cyc[id] = cyc;
                falls[id]    = 0;
            end
            if (!cs && sclk_prev[id] == 1 && !sclk) falls[id]++;
            if (cs_prev[id] == 0 && cs && in_frame[id] == 1) begin
                in_frame[id] = 0;
`ifdef ADC_FRAME_CHECK_EN
                exp_stb = (frame[id][15:12] == 4'b0000);
`else
                exp_stb = 1'b1;
                chk($sformatf("err_tied0_%0d", id), err, 0);
`endif
                chk($sformatf("strobe_%0d", id), stb, exp_stb);
                chk($sformatf("latency_%0d", id), cyc - fall_cyc[id], LAT);
                chk($sformatf("sclk_falls_%0d", id), falls[id], 16);
                if (exp_stb) begin
                    chk($sformatf("uk_model_%0d", id), $signed(uk), exp_uk(frame[id]));
                end else begin
                    chk($sformatf("uk_hold_%0d", id), uk, uk_prev[id]);
                    chk($sformatf("err_set_%0d", id), err, 1);
                end
                if (last_load[id] >= 0) chk($sformatf("load_spacing_%0d", id), cyc - last_load[id], spacing);
                last_load[id] = cyc;
                ld_strobe[id] = stb;
                ld_uk[id]     = uk;
                load_cnt[id]++;
            end else begin
                chk($sformatf("stray_strobe_%0d", id), stb, 0);
                chk($sformatf("uk_stable_%0d", id), uk, uk_prev[id]);
            end
        end
        cs_prev[id]   = cs;
        sclk_prev[id] = sclk;
        uk_prev[id]   = uk;
    endtask

    always @(negedge clk) monitor(0, rst_a_n, ifa.CS_n, ifa.SCLK, ifa.Bandera_ADC, ifa.Uk, ifa.Error_Trama, 2500);
    always @(negedge clk) monitor(1, rst_b_n, ifb.CS_n, ifb.SCLK, ifb.Bandera_ADC, ifb.Uk, ifb.Error_Trama, 200);

    task automatic wait_load(input int id, input int target, input int budget);
        int k = 0;
        while (load_cnt[id] < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk($sformatf("load_reached_%0d", id), load_cnt[id] >= target, 1);
    endtask

    typedef struct {
        logic [3:0]   lead;
        logic [11:0]  code;
        logic [N-1:0] exp_uk;
        logic         exp_stb;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n0;
        int k;

        vt[0] = '{4'h0, 12'hFFF, 25'h0007FF0, 1'b1};
        vt[1] = '{4'h0, 12'h800, 25'h0000000, 1'b1};
        vt[2] = '{4'h0, 12'h000, 25'h1FF8000, 1'b1};
        vt[3] = '{4'h0, 12'h001, 25'h1FF8010, 1'b1};
        vt[4] = '{4'h0, 12'h801, 25'h0000010, 1'b1};
`ifdef ADC_FRAME_CHECK_EN
        vt[5] = '{4'h4, 12'h123, 25'h0000010, 1'b0};
`else
        vt[5] = '{4'h4, 12'h123, 25'h1FF9230, 1'b1};
`endif
        vt[6] = '{4'h0, 12'h7FF, 25'h1FFFFF0, 1'b1};

        ifa.Enable = 1'b0;
        ifb.Enable = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", ifa.SCLK, 1);
        chk("rst_csn", ifa.CS_n, 1);
        chk("rst_uk", ifa.Uk, 0);
        chk("rst_strobe", ifa.Bandera_ADC, 0);
        chk("rst_overrun", ifa.Overrun, 0);
        chk("rst_err", ifa.Error_Trama, 0);

        // Release with Enable=1 and time the first CS_n fall
        adc_q.push_back({vt[0].lead, vt[0].code});
        n0 = load_cnt[0];
        ifa.Enable = 1'b1;
        @(posedge clk);
        #2 rst_a_n = 1'b1;
        k = 0;
        while (k < 3000) begin
            @(posedge clk);
            #1;
            k++;
            if (!ifa.CS_n) break;
        end
        chk("first_cs_fall", k, 2500);

        // Vector table on consecutive sample periods
        for (int i = 0; i < 7; i++) begin
            if (i > 0) adc_q.push_back({vt[i].lead, vt[i].code});
            wait_load(0, n0 + i + 1, 3000);
            chk($sformatf("vec%0d_strobe", i), ld_strobe[0], vt[i].exp_stb);
            chk($sformatf("vec%0d_uk", i), ld_uk[0], vt[i].exp_uk);
        end
`ifdef ADC_FRAME_CHECK_EN
        chk("err_after_bad_lead", ifa.Error_Trama, 1);
`else
        chk("err_after_bad_lead", ifa.Error_Trama, 0);
`endif
        chk("overrun_a_clear", ifa.Overrun, 0);

        // Reset at the 8th SCLK edge of a frame
        k = 0;
        while (k < 3000) begin
            @(posedge clk);
            #1;
            k++;
            if (!ifa.CS_n) break;
        end
        chk("cs_fall_before_abort", ifa.CS_n, 0);
        repeat (8 * CLK_DIV) @(posedge clk);
        #2 rst_a_n = 1'b0;
        #1;
        chk("abort_csn", ifa.CS_n, 1);
        chk("abort_sclk", ifa.SCLK, 1);
        chk("abort_strobe", ifa.Bandera_ADC, 0);
        chk("abort_uk", ifa.Uk, 0);
        repeat (3) @(posedge clk);
        #2 rst_a_n = 1'b1;
        adc_q.push_back(16'h0ABC);
        n0 = load_cnt[0];
        wait_load(0, n0 + 1, 3000);
        chk("post_abort_strobe", ld_strobe[0], 1);
        chk("post_abort_uk", ld_uk[0], 25'h0002BC0);

        // Overrun instance with random frames
        ifb.Enable = 1'b1;
        @(posedge clk);
        #2 rst_b_n = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        chk("overrun_before_tick2", ifb.Overrun, 0);
        repeat (60) @(posedge clk);
        #1;
        chk("overrun_after_tick2", ifb.Overrun, 1);
        wait_load(1, 40, 20000);
        chk("overrun_sticky", ifb.Overrun, 1);
        chk("overrun_a_final", ifa.Overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
